seven_seg_mux_driver: RTL and testbench

Time-multiplexed N-digit seven-segment display driver. It holds a double-buffered hex value and scans one digit per refresh slot, driving a shared segment/DP bus plus one anode per digit. On top of plain hex decoding it adds per-digit enable, leading-zero blanking, per-digit decimal point and anti-ghosting dead time. It sits between the counter/debouncer logic and the board's display pins.

---
 rtl/seven_seg_mux_driver.sv | 155 +++++++++++++++
 tb/tb_seven_seg_mux_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed seven-segment driver: double-buffered hex value, one digit per
// refresh slot, with per-digit enable, leading-zero blanking, decimal points and dead time.
module seven_seg_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      blank_lz,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // "Off" pin levels double as the XOR mask that maps lit/selected to pin polarity.
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] active;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   act_dp;

    logic                    tick;
    logic                    wrap;
    logic                    in_window;
    logic                    upper_zero;
    logic [NUM_DIGITS-1:0]   blanked;
    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic [3:0]              cur_nib;
    logic                    cur_en;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    show;
    logic [6:0]              lit;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    assign tick      = (cnt == CNT_LAST);
    assign wrap      = tick && (idx == IDX_LAST);
    assign in_window = (BLANK_CYCLES == 0) || (cnt >= CNT_BLANK);

    // Walk from the most significant digit down; a digit is blanked while every
    // nibble at or above it is zero. Digit 0 always shows.
    always_comb begin
        upper_zero = 1'b1;
        blanked    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (active[4*i +: 4] == 4'h0);
            blanked[i] = blank_lz && upper_zero && (i != 0);
        end
    end

    always_comb begin
        cur_nib    = '0;
        cur_en     = 1'b0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib       = active[4*i +: 4];
                cur_en        = digit_en[i];
                cur_dp        = act_dp[i];
                cur_blank     = blanked[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // A blanked digit keeps its decimal point; only a disabled digit or dead time kills dp.
    always_comb begin
        lit      = hex_to_seg(cur_nib);
        show     = in_window && cur_en && !cur_blank;
        an_next  = show ? (sel_onehot ^ AN_OFF) : AN_OFF;
        seg_next = show ? (lit ^ SEG_OFF) : SEG_OFF;
        dp_next  = (in_window && cur_en && cur_dp) ? ~DP_OFF : DP_OFF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            pending    <= '0;
            active     <= '0;
            pend_dp    <= '0;
            act_dp     <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (load) begin
                pending <= value;
                pend_dp <= dp_in;
            end
            // A load landing on the wrap edge bypasses the pending buffer.
            if (wrap) begin
                active <= load ? value : pending;
                act_dp <= load ? dp_in : pend_dp;
            end
            frame_done <= wrap;
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Directed bench for seven_seg_mux_driver: 4 digits, 8-cycle slots, 2 dead cycles,
// active-low segments and anodes. Vector table plus hand sequences for frame timing.
module tb_seven_seg_mux_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seven_seg_mux_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
        .digit_en(digit_en), .blank_lz(blank_lz), .seg(seg), .dp(dp),
        .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp_in;
        logic [3:0]  en;
        logic        lz;
        int          d;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Returns at the negedge where frame_done is seen (frame offset k=0).
    task automatic wait_frame();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_frame got timeout want frame_done");
        end
    endtask

    task automatic load_pulse(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    initial begin
        int n;
        int bad_hot, bad_en, seen0, seen2;

        vecs[0]  = '{16'h12AF, 4'b0100, 4'hF, 1'b0, 0, 4'b1110, 7'b0111000, 1'b1};
        vecs[1]  = '{16'h12AF, 4'b0100, 4'hF, 1'b0, 1, 4'b1101, 7'b0001000, 1'b1};
        vecs[2]  = '{16'h12AF, 4'b0100, 4'hF, 1'b0, 2, 4'b1011, 7'b0010010, 1'b0};
        vecs[3]  = '{16'h12AF, 4'b0100, 4'hF, 1'b0, 3, 4'b0111, 7'b1001111, 1'b1};
        vecs[4]  = '{16'h0050, 4'b0000, 4'hF, 1'b1, 3, 4'b1111, 7'b1111111, 1'b1};
        vecs[5]  = '{16'h0050, 4'b0000, 4'hF, 1'b1, 2, 4'b1111, 7'b1111111, 1'b1};
        vecs[6]  = '{16'h0050, 4'b0000, 4'hF, 1'b1, 1, 4'b1101, 7'b0100100, 1'b1};
        vecs[7]  = '{16'h0050, 4'b0000, 4'hF, 1'b1, 0, 4'b1110, 7'b0000001, 1'b1};
        vecs[8]  = '{16'h0050, 4'b0000, 4'hF, 1'b0, 3, 4'b0111, 7'b0000001, 1'b1};
        vecs[9]  = '{16'h0050, 4'b0000, 4'hF, 1'b0, 2, 4'b1011, 7'b0000001, 1'b1};
        vecs[10] = '{16'h0000, 4'b0000, 4'hF, 1'b1, 0, 4'b1110, 7'b0000001, 1'b1};
        vecs[11] = '{16'h0000, 4'b0000, 4'hF, 1'b1, 1, 4'b1111, 7'b1111111, 1'b1};
        vecs[12] = '{16'h8C3E, 4'b0010, 4'b0101, 1'b0, 1, 4'b1111, 7'b1111111, 1'b1};
        vecs[13] = '{16'h8C3E, 4'b0010, 4'b0101, 1'b0, 2, 4'b1011, 7'b0110001, 1'b1};
        vecs[14] = '{16'h8C3E, 4'b0010, 4'b0101, 1'b0, 0, 4'b1110, 7'b0110000, 1'b1};
        vecs[15] = '{16'h4967, 4'b1000, 4'hF, 1'b0, 3, 4'b0111, 7'b1001100, 1'b0};
        vecs[16] = '{16'h4967, 4'b1000, 4'hF, 1'b0, 2, 4'b1011, 7'b0000100, 1'b1};
        vecs[17] = '{16'h4967, 4'b1000, 4'hF, 1'b0, 1, 4'b1101, 7'b0100000, 1'b1};
        vecs[18] = '{16'h00BD, 4'b0000, 4'hF, 1'b1, 1, 4'b1101, 7'b1100000, 1'b1};
        vecs[19] = '{16'h00BD, 4'b0000, 4'hF, 1'b1, 0, 4'b1110, 7'b1000010, 1'b1};

        reset = 1'b1; value = '0; dp_in = '0; load = 1'b0;
        digit_en = 4'hF; blank_lz = 1'b0;

        // Reset state, then first frame_done 32 edges after release.
        wait_neg(3);
        check("rst_an",  16'(an),  16'h000F);
        check("rst_seg", 16'(seg), 16'h007F);
        check("rst_dp",  16'(dp),  16'h0001);
        check("rst_fd",  16'(frame_done), 16'h0000);
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            if (frame_done) n = i;
        end
        check("first_fd_cycle", 16'(n), 16'd32);
        @(negedge clk);
        check("fd_one_cycle", 16'(frame_done), 16'h0000);

        // Table vectors: load, let it become active at a wrap, inspect digit slot d.
        for (int v = 0; v < 20; v++) begin
            wait_frame();
            digit_en = vecs[v].en;
            blank_lz = vecs[v].lz;
            load_pulse(vecs[v].value, vecs[v].dp_in);
            wait_frame();
            wait_neg(8 * vecs[v].d + 2);
            check($sformatf("v%0d_dead_an", v), 16'(an), 16'h000F);
            @(negedge clk);
            check($sformatf("v%0d_an", v),  16'(an),  16'(vecs[v].an));
            check($sformatf("v%0d_seg", v), 16'(seg), 16'(vecs[v].seg));
            check($sformatf("v%0d_dp", v),  16'(dp),  16'(vecs[v].dp));
            wait_neg(5);
            check($sformatf("v%0d_end_an", v), 16'(an), 16'(vecs[v].an));
        end

        // Double buffering: mid-frame loads stay hidden until the wrap; load on wrap edge.
        digit_en = 4'hF; blank_lz = 1'b0;
        wait_frame();
        load_pulse(16'h9999, 4'b0000);
        wait_frame();
        wait_neg(10);
        load_pulse(16'h0001, 4'b0000);
        wait_neg(9);
        load_pulse(16'h0002, 4'b0000);
        wait_neg(8);
        check("hold_an",  16'(an),  16'h0007);
        check("hold_seg", 16'(seg), 16'h0004);
        wait_frame();
        wait_neg(5);
        check("swap_d0_seg", 16'(seg), 16'h0012);
        wait_neg(8);
        check("swap_d1_an",  16'(an),  16'h000D);
        check("swap_d1_seg", 16'(seg), 16'h0001);
        wait_neg(18);
        value = 16'h0003; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("wrap_load_fd", 16'(frame_done), 16'h0001);
        wait_neg(5);
        check("wrap_load_an",  16'(an),  16'h000E);
        check("wrap_load_seg", 16'(seg), 16'h0006);

        // Disabled digits never selected; at most one anode active over 10 frames.
        digit_en = 4'b0101;
        bad_hot = 0; bad_en = 0; seen0 = 0; seen2 = 0;
        for (int f = 0; f < 10; f++) begin
            wait_frame();
            blank_lz = f[0];
            value = 16'h0F0F ^ (16'(f) * 16'h1111);
            load = 1'b1;
            for (int c = 0; c < 32; c++) begin
                @(negedge clk);
                load = 1'b0;
                if ($countones(~an) > 1) bad_hot++;
                if (an == 4'b1101 || an == 4'b0111) bad_en++;
                if (an == 4'b1110) seen0++;
                if (an == 4'b1011) seen2++;
            end
        end
        check("onehot0_viol", 16'(bad_hot), 16'd0);
        check("disabled_sel", 16'(bad_en), 16'd0);
        check("d0_selected", 16'(seen0 > 0), 16'd1);
        check("d2_selected", 16'(seen2 > 0), 16'd1);

        // Reset during the digit 2 slot aborts it; scan restarts at digit 0 showing 0000.
        digit_en = 4'hF; blank_lz = 1'b0;
        load_pulse(16'h7777, 4'b1111);
        wait_frame();
        wait_frame();
        wait_neg(19);
        check("pre_rst_an", 16'(an), 16'h000B);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_an",  16'(an),  16'h000F);
        check("mid_rst_seg", 16'(seg), 16'h007F);
        check("mid_rst_dp",  16'(dp),  16'h0001);
        reset = 1'b0;
        wait_neg(2);
        check("post_rst_dead_an", 16'(an), 16'h000F);
        @(negedge clk);
        check("post_rst_d0_an",  16'(an),  16'h000E);
        check("post_rst_d0_seg", 16'(seg), 16'h0001);
        check("post_rst_d0_dp",  16'(dp),  16'h0001);
        wait_neg(8);
        check("post_rst_d1_an",  16'(an),  16'h000D);
        check("post_rst_d1_seg", 16'(seg), 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
